// File: rtl/fp_pkg.sv
// Shared floating-point definitions: field-width derivation, operand class flags
// and the expanded mantissa word shared by the align and normalize units.
package fp_pkg;

  function automatic int fp_emsb(input int fpwid);
    case (fpwid)
      16:      return 4;
      64:      return 10;
      128:     return 14;
      default: return 7;
    endcase
  endfunction

  function automatic int fp_fmsb(input int fpwid);
    return fpwid - fp_emsb(fpwid) - 3;
  endfunction

  // Expanded mantissa: {carry, hidden, frac, guard, sticky}
  function automatic int fp_mw(input int fpwid);
    return fp_fmsb(fpwid) + 5;
  endfunction

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
    logic sub;
  } fp_class_t;

  localparam int FP32_MW = fp_mw(32);
  typedef logic [FP32_MW-1:0] fp_mant32_t;

endpackage

// File: rtl/fp_rshift_sticky.sv
// Right barrel shift of the expanded mantissa; every bit shifted out is folded
// into bit 0 and also reported separately as the sticky flag.
module fp_rshift_sticky #(
  parameter int MW  = 27,
  parameter int SAW = 5
) (
  input  logic [MW-1:0]  din,
  input  logic [SAW-1:0] sa,
  output logic [MW-1:0]  dout,
  output logic           sticky
);

  logic [MW-1:0] shifted;
  logic [MW-1:0] lost_mask;

  always_comb begin
    shifted   = din >> sa;
    lost_mask = ~({MW{1'b1}} << sa);
    sticky    = |(din & lost_mask);
    dout      = {shifted[MW-1:1], shifted[0] | sticky};
  end

endmodule

// File: rtl/fp_denormalize.sv
// Unpacks an IEEE operand and right-aligns its expanded mantissa to a target
// exponent, three ce-gated stages with valid carried alongside the data.
module fp_denormalize
  import fp_pkg::*;
#(
  parameter int FPWID = 32
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    ce,
  input  logic                                    vld_i,
  input  logic [FPWID-1:0]                        a,
  input  logic [fp_emsb(FPWID):0]                 xtgt,
  output logic                                    vld_o,
  output logic [fp_emsb(FPWID)+fp_mw(FPWID)+1:0]  o,
  output logic                                    inf_o,
  output logic                                    nan_o,
  output logic                                    zero_o,
  output logic                                    inexact_o,
  output logic                                    err_o
);

  localparam int EMSB = fp_emsb(FPWID);
  localparam int FMSB = fp_fmsb(FPWID);
  localparam int MW   = fp_mw(FPWID);
  localparam int SAW  = $clog2(MW);

  logic [EMSB:0] exp_in;
  logic [FMSB:0] frac_in;
  fp_class_t     cls_in;

  always_comb begin
    exp_in      = a[FPWID-2 -: EMSB+1];
    frac_in     = a[FMSB:0];
    cls_in.zero = ~|exp_in & ~|frac_in;
    cls_in.sub  = ~|exp_in & |frac_in;
    cls_in.inf  = &exp_in & ~|frac_in;
    cls_in.nan  = &exp_in & |frac_in;
  end

  // Stage 1: unpack and classify
  logic          vld_p0, sign_p0;
  logic [EMSB:0] xeff_p0, xtgt_p0;
  logic [FMSB:0] frac_p0;
  fp_class_t     cls_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      sign_p0 <= 1'b0;
      xeff_p0 <= '0;
      xtgt_p0 <= '0;
      frac_p0 <= '0;
      cls_p0  <= '0;
    end else if (ce) begin
      vld_p0  <= vld_i;
      sign_p0 <= a[FPWID-1];
      xeff_p0 <= (exp_in == '0) ? (EMSB+1)'(1) : exp_in;
      xtgt_p0 <= xtgt;
      frac_p0 <= frac_in;
      cls_p0  <= cls_in;
    end
  end

  logic signed [EMSB+1:0] diff;
  logic                   special, err_c;
  logic [SAW-1:0]         sa_c;

  always_comb begin
    diff    = $signed({1'b0, xtgt_p0}) - $signed({1'b0, xeff_p0});
    special = cls_p0.zero | cls_p0.inf | cls_p0.nan;
    err_c   = diff[EMSB+1] & ~special;
    if (special || diff[EMSB+1])
      sa_c = '0;
    else if (diff[EMSB:0] > (EMSB+1)'(MW-1))
      sa_c = SAW'(MW-1);
    else
      sa_c = diff[SAW-1:0];
  end

  // Stage 2: shift amount and alignment error
  logic           vld_p1, sign_p1, err_p1;
  logic [EMSB:0]  xeff_p1, xtgt_p1;
  logic [FMSB:0]  frac_p1;
  logic [SAW-1:0] sa_p1;
  fp_class_t      cls_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      sign_p1 <= 1'b0;
      err_p1  <= 1'b0;
      xeff_p1 <= '0;
      xtgt_p1 <= '0;
      frac_p1 <= '0;
      sa_p1   <= '0;
      cls_p1  <= '0;
    end else if (ce) begin
      vld_p1  <= vld_p0;
      sign_p1 <= sign_p0;
      err_p1  <= err_c;
      xeff_p1 <= xeff_p0;
      xtgt_p1 <= xtgt_p0;
      frac_p1 <= frac_p0;
      sa_p1   <= sa_c;
      cls_p1  <= cls_p0;
    end
  end

  // A zero exponent field is exactly the zero-or-subnormal case, so hidden is rebuilt from class
  logic          hidden_p1;
  logic [MW-1:0] mant_pre, mant_sh;
  logic          sticky_c;

  assign hidden_p1 = ~(cls_p1.zero | cls_p1.sub);
  assign mant_pre  = {1'b0, hidden_p1, frac_p1, 2'b00};

  fp_rshift_sticky #(.MW(MW), .SAW(SAW)) u_rshift (
    .din    (mant_pre),
    .sa     (sa_p1),
    .dout   (mant_sh),
    .sticky (sticky_c)
  );

  // Stage 3: shifted mantissa and output exponent
  logic          vld_p2, sign_p2;
  logic [EMSB:0] exp_p2;
  logic [MW-1:0] mant_p2;
  logic          inf_p2, nan_p2, zero_p2, inexact_p2, err_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2     <= 1'b0;
      sign_p2    <= 1'b0;
      exp_p2     <= '0;
      mant_p2    <= '0;
      inf_p2     <= 1'b0;
      nan_p2     <= 1'b0;
      zero_p2    <= 1'b0;
      inexact_p2 <= 1'b0;
      err_p2     <= 1'b0;
    end else if (ce) begin
      vld_p2     <= vld_p1;
      sign_p2    <= sign_p1;
      exp_p2     <= (cls_p1.inf | cls_p1.nan | err_p1) ? xeff_p1 : xtgt_p1;
      mant_p2    <= mant_sh;
      inf_p2     <= cls_p1.inf;
      nan_p2     <= cls_p1.nan;
      zero_p2    <= cls_p1.zero;
      inexact_p2 <= sticky_c;
      err_p2     <= err_p1;
    end
  end

  assign vld_o     = vld_p2;
  assign o         = {sign_p2, exp_p2, mant_p2};
  assign inf_o     = inf_p2;
  assign nan_o     = nan_p2;
  assign zero_o    = zero_p2;
  assign inexact_o = inexact_p2;
  assign err_o     = err_p2;

endmodule

// File: tb/tb_fp_denormalize.sv
// Directed bench for fp_denormalize at FPWID=32: vector table plus ce-stall
// and mid-flight reset sequences.
module tb_fp_denormalize;

  logic        clk = 1'b0;
  logic        rst, ce, vld_i;
  logic [31:0] a;
  logic [7:0]  xtgt;
  logic        vld_o, inf_o, nan_o, zero_o, inexact_o, err_o;
  logic [35:0] o;

  int n_cmp = 0;
  int n_err = 0;

  fp_denormalize #(.FPWID(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .vld_i     (vld_i),
    .a         (a),
    .xtgt      (xtgt),
    .vld_o     (vld_o),
    .o         (o),
    .inf_o     (inf_o),
    .nan_o     (nan_o),
    .zero_o    (zero_o),
    .inexact_o (inexact_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  // flags = {zero, inf, nan, inexact, err}
  typedef struct {
    string       name;
    logic [31:0] a;
    logic [7:0]  xtgt;
    logic [35:0] o;
    logic [4:0]  flags;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic c, input logic v, input logic [31:0] av, input logic [7:0] xv);
    @(negedge clk);
    ce = c; vld_i = v; a = av; xtgt = xv;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] flags_now();
    return {zero_o, inf_o, nan_o, inexact_o, err_o};
  endfunction

  task automatic check_out(input string name, input logic [35:0] eo, input logic [4:0] ef);
    check({name, ".vld"}, 64'(vld_o), 64'(1'b1));
    check({name, ".o"}, 64'(o), 64'(eo));
    check({name, ".flags"}, 64'(flags_now()), 64'(ef));
  endtask

  initial begin
    vecs[0]  = '{"one_x7f",   32'h3F800000, 8'h7F, {1'b0, 8'h7F, 27'h2000000}, 5'b00000};
    vecs[1]  = '{"one_x81",   32'h3F800000, 8'h81, {1'b0, 8'h81, 27'h0800000}, 5'b00000};
    vecs[2]  = '{"sat_shift", 32'h3F800001, 8'hFE, {1'b0, 8'hFE, 27'h0000001}, 5'b00010};
    vecs[3]  = '{"subnorm",   32'h00000001, 8'h01, {1'b0, 8'h01, 27'h0000004}, 5'b00000};
    vecs[4]  = '{"neg_zero",  32'h80000000, 8'h7F, {1'b1, 8'h7F, 27'h0000000}, 5'b10000};
    vecs[5]  = '{"inf",       32'h7F800000, 8'h80, {1'b0, 8'hFF, 27'h2000000}, 5'b01000};
    vecs[6]  = '{"err",       32'h3F800000, 8'h7E, {1'b0, 8'h7F, 27'h2000000}, 5'b00001};
    vecs[7]  = '{"nan",       32'hFFC00000, 8'h10, {1'b1, 8'hFF, 27'h3000000}, 5'b00100};
    vecs[8]  = '{"sticky_sa3",32'h3F800001, 8'h82, {1'b0, 8'h82, 27'h0400001}, 5'b00010};
    vecs[9]  = '{"sa26",      32'h3F800000, 8'h99, {1'b0, 8'h99, 27'h0000001}, 5'b00010};
    vecs[10] = '{"sa25",      32'h3F800000, 8'h98, {1'b0, 8'h98, 27'h0000001}, 5'b00000};
    vecs[11] = '{"sub_sa2",   32'h00000003, 8'h03, {1'b0, 8'h03, 27'h0000003}, 5'b00000};
    vecs[12] = '{"zero_x00",  32'h00000000, 8'h00, {1'b0, 8'h00, 27'h0000000}, 5'b10000};

    rst = 1'b1; ce = 1'b0; vld_i = 1'b0; a = '0; xtgt = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.vld", 64'(vld_o), 64'(1'b0));
    check("reset.o", 64'(o), 64'h0);
    check("reset.flags", 64'(flags_now()), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      step(1'b1, 1'b1, vecs[i].a, vecs[i].xtgt);
      check({vecs[i].name, ".lat1"}, 64'(vld_o), 64'(1'b0));
      step(1'b1, 1'b0, 32'h0, 8'h0);
      check({vecs[i].name, ".lat2"}, 64'(vld_o), 64'(1'b0));
      step(1'b1, 1'b0, 32'h0, 8'h0);
      check_out(vecs[i].name, vecs[i].o, vecs[i].flags);
    end

    // Back-to-back operands with ce stalls: A, (stall), B, C, (stall), drain
    step(1'b1, 1'b1, vecs[0].a, vecs[0].xtgt);
    step(1'b0, 1'b1, vecs[1].a, vecs[1].xtgt);
    check("ce.stall_in", 64'(vld_o), 64'(1'b0));
    step(1'b1, 1'b1, vecs[1].a, vecs[1].xtgt);
    check("ce.pre_a", 64'(vld_o), 64'(1'b0));
    step(1'b1, 1'b1, vecs[3].a, vecs[3].xtgt);
    check_out("ce.A", vecs[0].o, vecs[0].flags);
    step(1'b0, 1'b0, 32'h0, 8'h0);
    check_out("ce.A_held", vecs[0].o, vecs[0].flags);
    step(1'b1, 1'b0, 32'h0, 8'h0);
    check_out("ce.B", vecs[1].o, vecs[1].flags);
    step(1'b1, 1'b0, 32'h0, 8'h0);
    check_out("ce.C", vecs[3].o, vecs[3].flags);
    step(1'b1, 1'b0, 32'h0, 8'h0);
    check("ce.drain", 64'(vld_o), 64'(1'b0));

    // Reset with two operands in flight
    step(1'b1, 1'b1, vecs[0].a, vecs[0].xtgt);
    step(1'b1, 1'b1, vecs[1].a, vecs[1].xtgt);
    rst = 1'b1;
    #1;
    check("rst.async_vld", 64'(vld_o), 64'(1'b0));
    check("rst.async_o", 64'(o), 64'h0);
    @(negedge clk);
    rst = 1'b0; vld_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 32'h0, 8'h0);
      check($sformatf("rst.flush%0d", k), 64'(vld_o), 64'(1'b0));
    end
    step(1'b1, 1'b1, vecs[8].a, vecs[8].xtgt);
    check("rst.new1", 64'(vld_o), 64'(1'b0));
    step(1'b1, 1'b0, 32'h0, 8'h0);
    check("rst.new2", 64'(vld_o), 64'(1'b0));
    step(1'b1, 1'b0, 32'h0, 8'h0);
    check_out("rst.new", vecs[8].o, vecs[8].flags);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
